// File: rtl/dacmux_scan_if.sv
`default_nettype none
// ============================================================================
// Module   : dacmux_scan_if
// Brief    : Control/data bundle between a scan controller and the SAR front end.
// Revision : 1.0
// ============================================================================
interface dacmux_scan_if #(
   parameter int NCH = 18,
   parameter int DW  = 10,
   parameter int CHW = 5
);
   logic           start;
   logic           stop;
   logic [NCH-1:0] ch_en;
   logic           cont;
   logic           res_full;
   logic [3:0]     settle;
   logic           comp;
   logic [DW-1:0]  dac_code;
   logic [CHW-1:0] mux_sel;
   logic           sample;
   logic           busy;
   logic           res_we;
   logic [CHW-1:0] res_ch;
   logic [DW-1:0]  res_data;
   logic           done;

   modport master (
      output start, stop, ch_en, cont, res_full, settle, comp,
      input  dac_code, mux_sel, sample, busy, res_we, res_ch, res_data, done
   );

   modport slave (
      input  start, stop, ch_en, cont, res_full, settle, comp,
      output dac_code, mux_sel, sample, busy, res_we, res_ch, res_data, done
   );
endinterface
`default_nettype wire

// File: rtl/dacmux_scan.sv
`default_nettype none
// ============================================================================
// Module   : dacmux_scan
// Brief    : Multi-channel SAR scan controller driving a DAC and analog mux.
// Revision : 1.0
// ============================================================================
module dacmux_scan #(
   parameter int NCH = 18,
   parameter int DW  = 10,
   parameter int CHW = 5
) (
   input  logic         clk,
   input  logic         srst,
   dacmux_scan_if.slave io_bus
);
   localparam int            BW         = $clog2(DW);
   localparam logic [BW-1:0] c_BIT_MSB  = BW'(DW - 1);
   localparam logic [BW-1:0] c_BIT_LSB8 = BW'(DW - 8);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_SEL    = 3'd1,
      S_SETTLE = 3'd2,
      S_CONV   = 3'd3,
      S_STORE  = 3'd4
   } state_t;

   // Returns {found, index} of the lowest set bit of v at or above base.
   function automatic logic [CHW:0] find_first(input logic [NCH-1:0] v,
                                               input logic [CHW:0]   base);
      logic [CHW:0] hit;
      hit = '0;
      for (int i = NCH - 1; i >= 0; i--) begin
         if (v[i] && (i >= int'(base))) hit = {1'b1, CHW'(i)};
      end
      return hit;
   endfunction

   state_t         r_state, w_nxt_state;
   logic [NCH-1:0] r_en, w_nxt_en;
   logic [CHW:0]   r_ptr, w_nxt_ptr;
   logic [3:0]     r_cnt, w_nxt_cnt;
   logic [BW-1:0]  r_bit, w_nxt_bit;
   logic           r_full, w_nxt_full;
   logic           r_stop_pend, w_nxt_stop_pend;
   logic [DW-1:0]  r_dac, w_nxt_dac;
   logic [CHW-1:0] r_mux, w_nxt_mux;
   logic           r_sample, w_nxt_sample;
   logic           r_busy, w_nxt_busy;
   logic           r_we, w_nxt_we;
   logic [CHW-1:0] r_res_ch, w_nxt_res_ch;
   logic [DW-1:0]  r_res_data, w_nxt_res_data;
   logic           r_done, w_nxt_done;

   logic [DW-1:0]  w_mask;
   logic [DW-1:0]  w_resolved;
   logic [BW-1:0]  w_last_bit;
   logic [CHW:0]   w_base;
   logic [CHW:0]   w_en_hit;
   logic [CHW:0]   w_new_hit;

   assign w_mask     = {{(DW-1){1'b0}}, 1'b1} << r_bit;
   assign w_resolved = io_bus.comp ? r_dac : (r_dac & ~w_mask);
   assign w_last_bit = r_full ? '0 : c_BIT_LSB8;
   assign w_base     = (r_state == S_STORE) ? r_ptr
                                            : ({1'b0, r_mux} + {{CHW{1'b0}}, 1'b1});
   assign w_en_hit   = find_first(r_en, w_base);
   assign w_new_hit  = find_first(io_bus.ch_en, '0);

   always_ff @(posedge clk) begin
      if (srst) begin
         r_state     <= S_IDLE;
         r_en        <= '0;
         r_ptr       <= '0;
         r_cnt       <= '0;
         r_bit       <= '0;
         r_full      <= 1'b0;
         r_stop_pend <= 1'b0;
         r_dac       <= '0;
         r_mux       <= '0;
         r_sample    <= 1'b0;
         r_busy      <= 1'b0;
         r_we        <= 1'b0;
         r_res_ch    <= '0;
         r_res_data  <= '0;
         r_done      <= 1'b0;
      end else begin
         r_state     <= w_nxt_state;
         r_en        <= w_nxt_en;
         r_ptr       <= w_nxt_ptr;
         r_cnt       <= w_nxt_cnt;
         r_bit       <= w_nxt_bit;
         r_full      <= w_nxt_full;
         r_stop_pend <= w_nxt_stop_pend;
         r_dac       <= w_nxt_dac;
         r_mux       <= w_nxt_mux;
         r_sample    <= w_nxt_sample;
         r_busy      <= w_nxt_busy;
         r_we        <= w_nxt_we;
         r_res_ch    <= w_nxt_res_ch;
         r_res_data  <= w_nxt_res_data;
         r_done      <= w_nxt_done;
      end
   end

   // Outputs are registered, so each branch computes what the next cycle shows.
   always_comb begin
      w_nxt_state     = r_state;
      w_nxt_en        = r_en;
      w_nxt_ptr       = r_ptr;
      w_nxt_cnt       = r_cnt;
      w_nxt_bit       = r_bit;
      w_nxt_full      = r_full;
      w_nxt_stop_pend = 1'b0;
      w_nxt_dac       = '0;
      w_nxt_mux       = r_mux;
      w_nxt_sample    = 1'b0;
      w_nxt_we        = 1'b0;
      w_nxt_res_ch    = r_res_ch;
      w_nxt_res_data  = r_res_data;
      w_nxt_done      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (io_bus.start && !io_bus.stop && w_new_hit[CHW]) begin
               w_nxt_state = S_SEL;
               w_nxt_en    = io_bus.ch_en;
               w_nxt_ptr   = '0;
               w_nxt_mux   = w_new_hit[CHW-1:0];
            end
         end
         S_SEL: begin
            if (io_bus.stop) begin
               w_nxt_state = S_IDLE;
            end else begin
               w_nxt_state  = S_SETTLE;
               w_nxt_cnt    = io_bus.settle;
               w_nxt_full   = io_bus.res_full;
               w_nxt_sample = 1'b1;
            end
         end
         S_SETTLE: begin
            if (io_bus.stop) begin
               w_nxt_state = S_IDLE;
            end else if (r_cnt == 4'd0) begin
               w_nxt_state = S_CONV;
               w_nxt_bit   = c_BIT_MSB;
               w_nxt_dac   = {1'b1, {(DW-1){1'b0}}};
            end else begin
               w_nxt_cnt    = r_cnt - 4'd1;
               w_nxt_sample = 1'b1;
            end
         end
         S_CONV: begin
            // A stop on the final trial still stores the finished result.
            if (r_bit == w_last_bit) begin
               w_nxt_state     = S_STORE;
               w_nxt_we        = 1'b1;
               w_nxt_res_ch    = r_mux;
               w_nxt_res_data  = w_resolved;
               w_nxt_done      = ~w_en_hit[CHW] & ~io_bus.stop;
               w_nxt_ptr       = {1'b0, r_mux} + {{CHW{1'b0}}, 1'b1};
               w_nxt_stop_pend = io_bus.stop;
            end else if (io_bus.stop) begin
               w_nxt_state = S_IDLE;
            end else begin
               w_nxt_bit = r_bit - BW'(1);
               w_nxt_dac = w_resolved | (w_mask >> 1);
            end
         end
         S_STORE: begin
            if (io_bus.stop || r_stop_pend) begin
               w_nxt_state = S_IDLE;
            end else if (w_en_hit[CHW]) begin
               w_nxt_state = S_SEL;
               w_nxt_mux   = w_en_hit[CHW-1:0];
            end else if (io_bus.cont && w_new_hit[CHW]) begin
               w_nxt_state = S_SEL;
               w_nxt_en    = io_bus.ch_en;
               w_nxt_ptr   = '0;
               w_nxt_mux   = w_new_hit[CHW-1:0];
            end else begin
               w_nxt_state = S_IDLE;
               if (io_bus.cont) w_nxt_en = io_bus.ch_en;
            end
         end
         default: w_nxt_state = S_IDLE;
      endcase
      w_nxt_busy = (w_nxt_state != S_IDLE);
   end

   assign io_bus.dac_code = r_dac;
   assign io_bus.mux_sel  = r_mux;
   assign io_bus.sample   = r_sample;
   assign io_bus.busy     = r_busy;
   assign io_bus.res_we   = r_we;
   assign io_bus.res_ch   = r_res_ch;
   assign io_bus.res_data = r_res_data;
   assign io_bus.done     = r_done;
endmodule
`default_nettype wire

// File: tb/tb_dacmux_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_dacmux_scan
// Brief    : Directed self-checking bench for dacmux_scan with an ideal comparator.
// Revision : 1.0
// ============================================================================
module tb_dacmux_scan;
   localparam int NCH = 18;
   localparam int DW  = 10;
   localparam int CHW = 5;

   logic clk = 1'b0;
   logic srst;
   always #5 clk = ~clk;

   dacmux_scan_if #(.NCH(NCH), .DW(DW), .CHW(CHW)) bus ();
   dacmux_scan #(.NCH(NCH), .DW(DW), .CHW(CHW)) u_dut (
      .clk    (clk),
      .srst   (srst),
      .io_bus (bus)
   );

   // Ideal analog front end: per-channel input voltage compared against the DAC.
   logic [DW-1:0] vin [32];
   assign bus.comp = (vin[bus.mux_sel] >= bus.dac_code);

   logic [63:0] w_outs;
   assign w_outs = {30'b0, bus.dac_code, bus.mux_sel, bus.sample, bus.busy,
                    bus.res_we, bus.res_ch, bus.res_data, bus.done};

   typedef struct packed {
      logic           done;
      logic [CHW-1:0] ch;
      logic [DW-1:0]  data;
   } wr_t;

   wr_t wr_q[$];
   int  done_cnt = 0;
   int  we_cyc   = 0;
   int  cyc      = 0;
   int  n_vec    = 0;
   int  n_miss   = 0;
   int  exp_ch[5] = '{0, 17, 0, 17, 0};

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (bus.res_we) begin
         wr_q.push_back('{bus.done, bus.res_ch, bus.res_data});
         we_cyc = cyc;
      end
      if (bus.done) done_cnt++;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input int maxc, input string tag);
      int n = 0;
      while (bus.busy && n < maxc) begin
         step();
         n++;
      end
      chk(tag, bus.busy, 0);
   endtask

   task automatic run_one(input int ch, input logic [DW-1:0] v, input logic full,
                          input logic [3:0] st, input logic [DW-1:0] exp, input string tag);
      int  n0;
      int  s0;
      wr_t w;
      vin[ch]      = v;
      bus.res_full = full;
      bus.settle   = st;
      bus.cont     = 1'b0;
      bus.ch_en    = {{(NCH-1){1'b0}}, 1'b1} << ch;
      n0           = wr_q.size();
      s0           = cyc;
      bus.start    = 1'b1;
      step();
      bus.start    = 1'b0;
      wait_idle(200, {tag, "_idle"});
      chk({tag, "_nwr"}, wr_q.size() - n0, 1);
      if (wr_q.size() > n0) begin
         w = wr_q[n0];
         chk({tag, "_data"}, w.data, exp);
         chk({tag, "_ch"}, w.ch, ch);
         chk({tag, "_lat"}, we_cyc - s0, int'(st) + (full ? DW : 8) + 3);
      end
   endtask

   initial begin
      int   n0;
      int   d0;
      int   k;
      logic seen;
      wr_t  w;

      srst         = 1'b1;
      bus.start    = 1'b0;
      bus.stop     = 1'b0;
      bus.ch_en    = '0;
      bus.cont     = 1'b0;
      bus.res_full = 1'b1;
      bus.settle   = 4'd0;
      for (int i = 0; i < 32; i++) vin[i] = '0;
      repeat (3) step();
      chk("reset_outs", w_outs, 64'd0);
      srst = 1'b0;
      step();

      // Start with nothing enabled is ignored.
      bus.start = 1'b1;
      seen      = 1'b0;
      step();
      bus.start = 1'b0;
      repeat (100) begin
         seen = seen | bus.busy | bus.res_we | bus.done;
         step();
      end
      chk("zero_en", seen, 0);

      // Start and stop together in IDLE: stop wins.
      bus.ch_en = 18'h00002;
      n0        = wr_q.size();
      bus.start = 1'b1;
      bus.stop  = 1'b1;
      step();
      bus.start = 1'b0;
      bus.stop  = 1'b0;
      chk("start_stop_busy", bus.busy, 0);
      repeat (30) step();
      chk("start_stop_nwr", wr_q.size() - n0, 0);

      // Single 10-bit channel, cycle-exact; ch_en changed mid-pass is ignored.
      vin[7]       = 10'h2BC;
      bus.settle   = 4'd2;
      bus.res_full = 1'b1;
      bus.ch_en    = 18'h00080;
      bus.start    = 1'b1;
      step();
      bus.start    = 1'b0;
      bus.ch_en    = 18'h3FFFF;
      for (int c = 1; c <= 16; c++) begin
         chk($sformatf("c%0d_busy", c), bus.busy, (c <= 15));
         chk($sformatf("c%0d_sample", c), bus.sample, (c >= 2 && c <= 4));
         chk($sformatf("c%0d_we", c), bus.res_we, (c == 15));
         chk($sformatf("c%0d_done", c), bus.done, (c == 15));
         if (c <= 15) chk($sformatf("c%0d_mux", c), bus.mux_sel, 7);
         if (c >= 2 && c <= 4) chk($sformatf("c%0d_dac", c), bus.dac_code, 0);
         if (c == 5) chk("c5_dac", bus.dac_code, 10'h200);
         if (c == 6) chk("c6_dac", bus.dac_code, 10'h300);
         if (c == 15) begin
            chk("c15_res_ch", bus.res_ch, 7);
            chk("c15_res_data", bus.res_data, 10'h2BC);
         end
         step();
      end

      // 8-bit mode and full/zero scale.
      run_one(3, 10'h3FF, 1'b0, 4'd0, 10'h3FC, "b8_hi");
      run_one(3, 10'h003, 1'b0, 4'd0, 10'h000, "b8_lo");
      run_one(12, 10'h3FF, 1'b1, 4'd5, 10'h3FF, "full_scale");
      run_one(12, 10'h000, 1'b1, 4'd15, 10'h000, "zero_scale");

      // Full one-shot scan of all channels.
      for (int i = 0; i < NCH; i++) vin[i] = DW'(57 * i);
      bus.ch_en    = 18'h3FFFF;
      bus.settle   = 4'd1;
      bus.res_full = 1'b1;
      bus.cont     = 1'b0;
      n0           = wr_q.size();
      d0           = done_cnt;
      bus.start    = 1'b1;
      step();
      bus.start    = 1'b0;
      wait_idle(1000, "scan_idle");
      chk("scan_nwr", wr_q.size() - n0, NCH);
      for (int i = 0; i < NCH && (n0 + i) < wr_q.size(); i++) begin
         w = wr_q[n0 + i];
         chk($sformatf("scan%0d_ch", i), w.ch, i);
         chk($sformatf("scan%0d_data", i), w.data, 57 * i);
      end
      chk("scan_done", done_cnt - d0, 1);

      // Continuous wrap over channels 0 and 17, then abort during CONV of 17.
      vin[0]       = 10'h155;
      vin[17]      = 10'h0AA;
      bus.ch_en    = 18'h20001;
      bus.cont     = 1'b1;
      bus.settle   = 4'd0;
      n0           = wr_q.size();
      d0           = done_cnt;
      bus.start    = 1'b1;
      step();
      bus.start    = 1'b0;
      k = 0;
      while ((wr_q.size() - n0) < 5 && k < 500) begin
         step();
         k++;
      end
      k = 0;
      while (!(bus.mux_sel == 5'd17 && bus.dac_code != '0) && k < 100) begin
         step();
         k++;
      end
      chk("cont_conv17", (bus.mux_sel == 5'd17 && bus.dac_code != '0), 1);
      bus.stop = 1'b1;
      step();
      bus.stop = 1'b0;
      chk("stop_busy", bus.busy, 0);
      chk("stop_dac", bus.dac_code, 0);
      chk("stop_sample", bus.sample, 0);
      repeat (40) step();
      chk("cont_nwr", wr_q.size() - n0, 5);
      for (int i = 0; i < 5 && (n0 + i) < wr_q.size(); i++) begin
         w = wr_q[n0 + i];
         chk($sformatf("cont%0d_ch", i), w.ch, exp_ch[i]);
         chk($sformatf("cont%0d_done", i), w.done, (exp_ch[i] == 17));
         chk($sformatf("cont%0d_data", i), w.data, (exp_ch[i] == 17) ? 10'h0AA : 10'h155);
      end
      chk("cont_done", done_cnt - d0, 2);
      bus.cont = 1'b0;

      // Reset in the middle of a conversion.
      vin[5]    = 10'h1A5;
      bus.ch_en = 18'h00020;
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      k = 0;
      while (bus.dac_code == '0 && k < 50) begin
         step();
         k++;
      end
      repeat (3) step();
      n0   = wr_q.size();
      srst = 1'b1;
      step();
      srst = 1'b0;
      chk("rst_mid_outs", w_outs, 64'd0);
      repeat (20) step();
      chk("rst_mid_nwr", wr_q.size() - n0, 0);
      run_one(5, 10'h1A5, 1'b1, 4'd0, 10'h1A5, "post_rst");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
`default_nettype wire
